// File: rtl/piso_pkg.sv
// Shared types for the PISO schedulers: frame FSM states and the PISO word width.
package piso_pkg;
  localparam int PISO_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} piso_state_t;
endpackage

// File: rtl/piso_tx_sched_rr_arb.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping.
module rr_arb #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  logic [IW-1:0] idx;

  // Walk from farthest to nearest so the nearest valid index wins.
  always_comb begin
    idx     = '0;
    gnt_idx = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) gnt_idx = idx;
    end
    any = |req;
    gnt = any ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/piso_tx_sched.sv
// Shares one PISO between N_REQ producers: round-robin grant, load, WIDTH shift
// cycles qualified by ser_valid/ser_id, then GAP idle cycles.
module piso_tx_sched #(
  parameter int WIDTH = piso_pkg::PISO_WIDTH,
  parameter int N_REQ = 2,
  parameter int GAP   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       piso_load,
  output logic [WIDTH-1:0]           piso_d,
  output logic                       ser_valid,
  output logic [$clog2(N_REQ)-1:0]   ser_id,
  output logic                       ser_last,
  output logic                       busy
);
  import piso_pkg::*;

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(WIDTH);
  localparam int GW = 3;

  piso_state_t   state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             any_req, grant, last_bit;

  rr_arb #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  // No accept while reset is high: a word taken then would be lost.
  assign grant    = (state_q == IDLE) && any_req && !reset;
  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == BW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d   = SHIFT;
          owner_d   = gnt_idx;
          rr_ptr_d  = (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (last_bit) begin
          state_d   = (GAP > 0) ? piso_pkg::GAP : IDLE;
          gap_cnt_d = '0;
        end
      end
      piso_pkg::GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GW'(GAP-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = grant ? gnt : '0;
    piso_load = grant;
    piso_d    = grant ? req_data[gnt_idx*WIDTH +: WIDTH] : '0;
    ser_valid = (state_q == SHIFT);
    ser_id    = ser_valid ? owner_q : '0;
    ser_last  = last_bit;
    busy      = (state_q != IDLE);
  end
endmodule
